cgra_clock_gate_ctrl: RTL

Multi-channel, glitch-free clock-gating controller for the CGRA. It replaces per-tile static gating with automatic idle-based gating and exposes a hysteresis counter, forced-on override and a wake handshake for each channel. Each channel drives one gated clock to a CGRA column or peripheral group. The block sits between the CGRA controller (busy/wake sources) and the column clock trees.

---
 rtl/cgra_clock_gate_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/cgra_clock_gate_ctrl.sv
// Multi-channel idle-based clock-gating controller: per-channel ON/COUNT/OFF/WAKE
// FSM with hold-off counter, feeding a low-transparent latch + AND clock gate.
module cgra_clock_gate_ctrl #(
  parameter int N_CH       = 4,
  parameter int IDLE_CNT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_en_i,
  input  logic [N_CH-1:0]       auto_en_i,
  input  logic [N_CH-1:0]       force_on_i,
  input  logic [N_CH-1:0]       busy_i,
  input  logic [N_CH-1:0]       wake_req_i,
  input  logic [IDLE_CNT_W-1:0] holdoff_i,
  output logic [N_CH-1:0]       clk_o,
  output logic [N_CH-1:0]       gated_o,
  output logic [N_CH-1:0]       wake_ack_o,
  output logic                  all_gated_o
);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_COUNT = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_e                  state_q, state_d;
      logic [IDLE_CNT_W-1:0]   cnt_q, cnt_d;
      logic                    stay_on;
      logic                    enable;
      logic                    en_latch;

      assign stay_on = force_on_i[gi] | ~auto_en_i[gi] | busy_i[gi] | wake_req_i[gi];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= ST_ON;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // stay_on wins over an expiring count; the counter saturates at zero
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enable  = 1'b1;
        case (state_q)
          ST_ON: begin
            if (!stay_on) begin
              state_d = ST_COUNT;
              cnt_d   = holdoff_i;
            end
          end
          ST_COUNT: begin
            if (stay_on) begin
              state_d = ST_ON;
            end else if (cnt_q == '0) begin
              state_d = ST_OFF;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          ST_OFF: begin
            enable = 1'b0;
            if (stay_on) begin
              state_d = ST_WAKE;
            end
          end
          ST_WAKE: begin
            state_d = ST_ON;
          end
          default: begin
            state_d = ST_ON;
          end
        endcase
      end

      // Latch is only open while clk_i is low, so enable changes never chop a high phase
      always_latch begin
        if (!clk_i) begin
          en_latch = enable | test_en_i;
        end
      end

      assign clk_o[gi]      = clk_i & en_latch;
      assign gated_o[gi]    = (state_q == ST_OFF);
      assign wake_ack_o[gi] = (state_q == ST_WAKE);
    end
  endgenerate

  assign all_gated_o = &gated_o;

endmodule
